run_controller: RTL and testbench

- Sequences the single-cycle processor's PC/commit enable (the `enable` of the PC register and the gating of RegWrite/MemWrite/lcd_write/keyboard_ack) so the core can run freely, single-step, halt, or stop on a hardware breakpoint.
- Sits between the board buttons/switches and the processor top level.
- Also keeps a retired-instruction count for the hex displays.

---
 rtl/run_controller_pkg.sv | 23 ++
 rtl/run_controller_sat_counter.sv | 34 +++
 rtl/run_controller.sv | 130 +++++++++++++
 tb/tb_run_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_controller_pkg.sv
//------------------------------------------------------------------------------
// Module : run_controller_pkg
// Brief  : Shared run-control state encodings and core address width.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package run_controller_pkg;

    localparam int c_ADDR_W = 12;

    localparam logic [1:0] c_STATE_HALT  = 2'd0;
    localparam logic [1:0] c_STATE_RUN   = 2'd1;
    localparam logic [1:0] c_STATE_STEP  = 2'd2;
    localparam logic [1:0] c_STATE_BREAK = 2'd3;

    function automatic logic isHaltedState(input logic [1:0] stateCode);
        return (stateCode == c_STATE_HALT) || (stateCode == c_STATE_BREAK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/run_controller_sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Enabled up-counter with asynchronous clear that sticks at all-ones.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_atMax;

    assign w_atMax = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_enable && !w_atMax) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/run_controller.sv
//------------------------------------------------------------------------------
// Module : run_controller
// Brief  : Run / step / halt / breakpoint sequencer for the core's PC enable.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module run_controller
    import run_controller_pkg::*;
#(
    parameter int ADDR_W        = c_ADDR_W,
    parameter int CNT_W         = 32,
    parameter int START_RUNNING = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              bp_enable,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_enable,
    output logic              halted,
    output logic              bp_hit,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0] c_RESET_STATE = (START_RUNNING != 0) ? c_STATE_RUN : c_STATE_HALT;

    logic [1:0] r_state;
    logic       r_skipBp;
    logic       r_bpHit;
    logic       r_halted;

    logic [1:0] w_nextState;
    logic       w_nextSkip;
    logic       w_bpMatch;
    logic       w_pcEnable;

    // skip_bp lets the breakpointed instruction commit once after resuming
    assign w_bpMatch = bp_enable && (pc == bp_addr) && !r_skipBp;

    always_comb begin
        w_pcEnable = 1'b0;
        case (r_state)
            c_STATE_RUN:  w_pcEnable = !w_bpMatch;
            c_STATE_STEP: w_pcEnable = 1'b1;
            default:      w_pcEnable = 1'b0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_nextSkip  = r_skipBp;
        if (w_pcEnable) begin
            w_nextSkip = 1'b0;
        end
        case (r_state)
            c_STATE_HALT: begin
                if (halt_req) begin
                    w_nextState = c_STATE_HALT;
                end else if (step_req) begin
                    w_nextState = c_STATE_STEP;
                end else if (run_req) begin
                    w_nextState = c_STATE_RUN;
                end
            end
            c_STATE_RUN: begin
                if (halt_req) begin
                    w_nextState = c_STATE_HALT;
                end else if (w_bpMatch) begin
                    w_nextState = c_STATE_BREAK;
                end
            end
            c_STATE_STEP: begin
                w_nextState = c_STATE_HALT;
            end
            c_STATE_BREAK: begin
                if (halt_req) begin
                    w_nextState = c_STATE_HALT;
                end else if (step_req) begin
                    w_nextState = c_STATE_STEP;
                    w_nextSkip  = 1'b1;
                end else if (run_req) begin
                    w_nextState = c_STATE_RUN;
                    w_nextSkip  = 1'b1;
                end
            end
            default: begin
                w_nextState = c_STATE_HALT;
            end
        endcase
        if (w_nextState == c_STATE_HALT) begin
            w_nextSkip = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_RESET_STATE;
            r_skipBp <= 1'b0;
            r_bpHit  <= 1'b0;
            r_halted <= (START_RUNNING == 0);
        end else begin
            r_state  <= w_nextState;
            r_skipBp <= w_nextSkip;
            r_bpHit  <= (w_nextState == c_STATE_BREAK);
            r_halted <= isHaltedState(w_nextState);
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_retiredCounter (
        .clk      (clock),
        .rst      (reset),
        .i_enable (w_pcEnable),
        .o_count  (retired)
    );

    assign pc_enable = w_pcEnable;
    assign state     = r_state;
    assign bp_hit    = r_bpHit;
    assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
//------------------------------------------------------------------------------
// Module : tb_run_controller
// Brief  : Directed vector and sequence bench for run_controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        runReq = 1'b0, stepReq = 1'b0, haltReq = 1'b0, bpEnable = 1'b0;
    logic [11:0] bpAddr = '0, pc = '0;
    logic        pcEnable, halted, bpHit;
    logic [1:0]  state;
    logic [31:0] retired;

    logic        zeroBit = 1'b0;
    logic [11:0] zeroAddr = '0;
    logic        pcEnable2, halted2, bpHit2;
    logic [1:0]  state2;
    logic [3:0]  retired2;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clock = ~clock;

    run_controller #(.ADDR_W(12), .CNT_W(32), .START_RUNNING(0)) dut (
        .clock(clock), .reset(reset), .run_req(runReq), .step_req(stepReq),
        .halt_req(haltReq), .bp_enable(bpEnable), .bp_addr(bpAddr), .pc(pc),
        .pc_enable(pcEnable), .halted(halted), .bp_hit(bpHit), .state(state),
        .retired(retired)
    );

    run_controller #(.ADDR_W(12), .CNT_W(4), .START_RUNNING(1)) dutSmall (
        .clock(clock), .reset(reset), .run_req(zeroBit), .step_req(zeroBit),
        .halt_req(zeroBit), .bp_enable(zeroBit), .bp_addr(zeroAddr), .pc(zeroAddr),
        .pc_enable(pcEnable2), .halted(halted2), .bp_hit(bpHit2), .state(state2),
        .retired(retired2)
    );

    typedef struct {
        logic        run, step, halt, bpEn;
        logic [11:0] bpA, pcVal;
        logic        expPcEn;
        logic [1:0]  expState;
        logic        expHalted, expBpHit;
        logic [31:0] expRetired;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void addVec(input logic run, input logic step, input logic halt,
                                   input logic [11:0] pcVal, input logic expPcEn,
                                   input logic [1:0] expState, input logic expHalted,
                                   input logic [31:0] expRetired);
        vec_t v;
        v = '{run, step, halt, 1'b0, 12'h000, pcVal, expPcEn, expState, expHalted, 1'b0, expRetired};
        vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge; pc_enable is checked just after, registered outputs just after the rising edge.
    task automatic applyVec(input vec_t v, input int idx);
        @(negedge clock);
        runReq = v.run; stepReq = v.step; haltReq = v.halt;
        bpEnable = v.bpEn; bpAddr = v.bpA; pc = v.pcVal;
        #1;
        check($sformatf("vec%0d pc_enable", idx), {31'd0, pcEnable}, {31'd0, v.expPcEn});
        @(posedge clock);
        #1;
        check($sformatf("vec%0d state", idx), {30'd0, state}, {30'd0, v.expState});
        check($sformatf("vec%0d halted", idx), {31'd0, halted}, {31'd0, v.expHalted});
        check($sformatf("vec%0d bp_hit", idx), {31'd0, bpHit}, {31'd0, v.expBpHit});
        check($sformatf("vec%0d retired", idx), retired, v.expRetired);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        runReq = 1'b0; stepReq = 1'b0; haltReq = 1'b0;
        #2;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic en;
        logic hit;
        int   commits;

        // Idle after reset, then single steps, then halt+step collision, then requests ignored in STEP
        for (int i = 0; i < 10; i++) addVec(0, 0, 0, 12'h000, 0, 2'd0, 1, 0);
        addVec(0, 1, 0, 12'h005, 0, 2'd2, 0, 0);
        addVec(0, 0, 0, 12'h005, 1, 2'd0, 1, 1);
        addVec(0, 0, 0, 12'h006, 0, 2'd0, 1, 1);
        addVec(0, 1, 0, 12'h006, 0, 2'd2, 0, 1);
        addVec(0, 0, 0, 12'h006, 1, 2'd0, 1, 2);
        addVec(1, 0, 0, 12'h007, 0, 2'd1, 0, 2);
        addVec(0, 0, 0, 12'h007, 1, 2'd1, 0, 3);
        addVec(0, 1, 1, 12'h008, 1, 2'd0, 1, 4);
        addVec(0, 0, 0, 12'h009, 0, 2'd0, 1, 4);
        addVec(0, 1, 0, 12'h009, 0, 2'd2, 0, 4);
        addVec(1, 0, 1, 12'h009, 1, 2'd0, 1, 5);
        addVec(0, 0, 0, 12'h00A, 0, 2'd0, 1, 5);

        #12;
        check("reset state", {30'd0, state}, 32'd0);
        check("reset halted", {31'd0, halted}, 32'd1);
        check("reset bp_hit", {31'd0, bpHit}, 32'd0);
        check("reset retired", retired, 32'd0);
        check("reset pc_enable", {31'd0, pcEnable}, 32'd0);
        check("reset small state", {30'd0, state2}, 32'd1);
        check("reset small halted", {31'd0, halted2}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

        // Free run into a breakpoint at 0x010, resume past it, loop back to it
        doReset();
        bpEnable = 1'b1; bpAddr = 12'h010; pc = 12'h000;
        runReq = 1'b1;
        @(posedge clock); #1;
        check("bp run entered", {30'd0, state}, 32'd1);
        @(negedge clock);
        runReq = 1'b0;
        commits = 0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            #1;
            en = pcEnable;
            if (en) commits++;
            @(posedge clock); #1;
            if (state == 2'd3) hit = 1'b1;
            @(negedge clock);
            if (en) pc = pc + 12'd1;
        end
        check("bp reached", {31'd0, hit}, 32'd1);
        check("bp commits", commits, 32'd16);
        check("bp pc", {20'd0, pc}, 32'h010);
        #1;
        check("bp pc_enable", {31'd0, pcEnable}, 32'd0);
        check("bp state", {30'd0, state}, 32'd3);
        check("bp bp_hit", {31'd0, bpHit}, 32'd1);
        check("bp halted", {31'd0, halted}, 32'd1);
        check("bp retired", retired, 32'd16);
        runReq = 1'b1;
        @(posedge clock); #1;
        check("resume state", {30'd0, state}, 32'd1);
        check("resume bp_hit", {31'd0, bpHit}, 32'd0);
        check("resume retired", retired, 32'd16);
        @(negedge clock);
        runReq = 1'b0;
        #1;
        check("skip pc_enable", {31'd0, pcEnable}, 32'd1);
        @(posedge clock); #1;
        check("skip retired", retired, 32'd17);
        check("skip state", {30'd0, state}, 32'd1);
        @(negedge clock);
        pc = 12'h011;
        #1;
        check("after bp pc_enable", {31'd0, pcEnable}, 32'd1);
        @(posedge clock); #1;
        check("after bp retired", retired, 32'd18);
        @(negedge clock);
        pc = 12'h010;
        #1;
        check("rebreak pc_enable", {31'd0, pcEnable}, 32'd0);
        @(posedge clock); #1;
        check("rebreak state", {30'd0, state}, 32'd3);
        check("rebreak bp_hit", {31'd0, bpHit}, 32'd1);
        check("rebreak retired", retired, 32'd18);
        @(negedge clock);
        bpEnable = 1'b0;
        @(posedge clock); #1;
        check("break hold state", {30'd0, state}, 32'd3);
        @(negedge clock);
        haltReq = 1'b1;
        @(posedge clock); #1;
        check("break halt state", {30'd0, state}, 32'd0);
        check("break halt bp_hit", {31'd0, bpHit}, 32'd0);
        check("break halt halted", {31'd0, halted}, 32'd1);
        @(negedge clock);
        haltReq = 1'b0;

        // Asynchronous reset in the middle of a RUN cycle
        doReset();
        bpEnable = 1'b0;
        runReq = 1'b1;
        @(posedge clock);
        @(negedge clock);
        runReq = 1'b0;
        repeat (50) @(posedge clock);
        #3;
        check("run retired 50", retired, 32'd50);
        reset = 1'b1;
        #1;
        check("async reset retired", retired, 32'd0);
        check("async reset state", {30'd0, state}, 32'd0);
        check("async reset pc_enable", {31'd0, pcEnable}, 32'd0);
        check("async reset halted", {31'd0, halted}, 32'd1);
        check("async reset small retired", {28'd0, retired2}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Narrow counter saturates while free-running
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); #1;
            check($sformatf("sat retired n=%0d", n), {28'd0, retired2}, (n > 15) ? 32'd15 : n);
        end
        check("sat state", {30'd0, state2}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
